// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the key debouncer: per-bit FSM state encoding and default filter length.
// No datapath; constants only.
package key_pkg;

  typedef enum logic [1:0] {
    ST_REL_STABLE   = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRS_STABLE   = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, polarity normalise, debounce FSM; optional release pulse (KEY_DEBOUNCE_RELEASE_PULSE_EN).
// Latency: 2 + DEBOUNCE_CYCLES clk edges from raw change to registered level/pulse.
// No backpressure: outputs are free-running levels and single-cycle pulses.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic key_release
`endif
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          REL_LVL  = (ACTIVE_LOW != 0);

  logic          sync1_q, sync2_q;
  logic          s;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  logic          release_q, release_d;
`endif

  assign s = sync2_q ^ REL_LVL;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
    release_d = 1'b0;
`endif
    case (state_q)
      ST_REL_STABLE: begin
        cnt_d = '0;
        if (s) begin
          // A single-cycle filter accepts the change on the first differing sample
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_PRS_STABLE;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_REL_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRS_STABLE;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRS_STABLE: begin
        cnt_d = '0;
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_REL_STABLE;
            level_d = 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
            release_d = 1'b1;
`endif
          end else begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_PRS_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_REL_STABLE;
          cnt_d   = '0;
          level_d = 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
          release_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_REL_STABLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
      state_q <= ST_REL_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
      release_q <= 1'b0;
`endif
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
    end
  end

  assign key_level = level_q;
  assign key_press = press_q;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  assign key_release = release_q;
`endif

endmodule

// File: rtl/key_debouncer.sv
// WIDTH independent debounced keys; key_release exists only with KEY_DEBOUNCE_RELEASE_PULSE_EN.
// Latency: 2 + DEBOUNCE_CYCLES clk edges, all outputs registered.
// No backpressure: level outputs and single-cycle pulses.
module key_debouncer
  import key_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic [WIDTH-1:0] key_release
`endif
);

  if (WIDTH < 1) begin : g_bad_width
    $error("key_debouncer: WIDTH must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("key_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_pol
    $error("key_debouncer: ACTIVE_LOW must be 0 or 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .key_raw     (key_raw[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i])
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
      ,
      .key_release (key_release[i])
`endif
    );
  end

endmodule
